operand_fetch: RTL and testbench



---
 rtl/operand_fetch_pkg.sv | 17 +
 rtl/operand_fetch_scoreboard.sv | 46 ++++
 rtl/operand_fetch.sv | 120 ++++++++++++
 tb/tb_operand_fetch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: register index width,
// architectural register count and the hard-wired zero register.
package operand_fetch_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t X0_IDX = '0;

  // True when a strobe targets a given non-zero register index.
  function automatic logic idx_hit(input logic en, input reg_idx_t a, input reg_idx_t b);
    return en && (a == b) && (b != X0_IDX);
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard for the operand-fetch stage. One bit per
// architectural register; set when a result leaves for execute, cleared by
// writeback. Lookups mask a bit whose writeback lands this same cycle, since
// that value is already available on the bypass path.
module opfetch_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  input  reg_idx_t rd_idx,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     rd_busy
);

  logic [NUM_ARCH_REGS-1:0] pend;
  logic [NUM_ARCH_REGS-1:0] pend_nxt;

  // Next pend vector: clear first so a same-index set wins; x0 never pends.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_idx] = 1'b0;
    if (set_en) pend_nxt[set_idx] = 1'b1;
    pend_nxt[X0_IDX] = 1'b0;
  end

  // Pend vector register; reset drops all outstanding writebacks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend <= '0;
    else          pend <= pend_nxt;
  end

  // Busy lookups, qualified by a same-cycle writeback to the same index.
  always_comb begin
    rs1_busy = pend[rs1_idx] && !idx_hit(clr_en, clr_idx, rs1_idx);
    rs2_busy = pend[rs2_idx] && !idx_hit(clr_en, clr_idx, rs2_idx);
    rd_busy  = pend[rd_idx]  && !idx_hit(clr_en, clr_idx, rd_idx);
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2 from the register file, bypasses
// same-cycle writeback data, stalls RAW/WAW hazards via a scoreboard and
// registers resolved operands into a valid/ready register feeding execute.
// Optional build macro: OPFETCH_STALL_CNT_EN adds a 32-bit stall counter output.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int TWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs1_idx,
  input  logic [4:0]        id_rs2_idx,
  input  logic [4:0]        id_rd_idx,
  input  logic              id_rd_we,
  input  logic [TWIDTH-1:0] id_tag,
  output logic [4:0]        rf_rs1_idx,
  output logic [4:0]        rf_rs2_idx,
  input  logic [DWIDTH-1:0] rf_rd_data_1,
  input  logic [DWIDTH-1:0] rf_rd_data_2,
  input  logic              wb_en,
  input  logic [4:0]        wb_idx,
  input  logic [DWIDTH-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DWIDTH-1:0] ex_op1,
  output logic [DWIDTH-1:0] ex_op2,
  output logic [4:0]        ex_rd_idx,
  output logic              ex_rd_we,
  output logic [TWIDTH-1:0] ex_tag
`ifdef OPFETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic [DWIDTH-1:0] op1;
  logic [DWIDTH-1:0] op2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_busy;
  logic              hazard;
  logic              id_fire;
  logic              sb_set;

  assign rf_rs1_idx = id_rs1_idx;
  assign rf_rs2_idx = id_rs2_idx;

  // A result leaving for execute becomes pending; a flushed one never does.
  assign sb_set = ex_valid && ex_ready && ex_rd_we && (ex_rd_idx != X0_IDX) && !flush;

  opfetch_scoreboard u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (sb_set),
    .set_idx  (ex_rd_idx),
    .clr_en   (wb_en),
    .clr_idx  (wb_idx),
    .rs1_idx  (id_rs1_idx),
    .rs2_idx  (id_rs2_idx),
    .rd_idx   (id_rd_idx),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Operand select: x0 reads zero, same-cycle writeback beats register file.
  always_comb begin
    op1 = rf_rd_data_1;
    op2 = rf_rd_data_2;
    if (id_rs1_idx == X0_IDX)                   op1 = '0;
    else if (idx_hit(wb_en, wb_idx, id_rs1_idx)) op1 = wb_data;
    if (id_rs2_idx == X0_IDX)                   op2 = '0;
    else if (idx_hit(wb_en, wb_idx, id_rs2_idx)) op2 = wb_data;
  end

  // Hazard: source or destination pending in the scoreboard, or about to be
  // produced by the instruction sitting in the output register.
  always_comb begin
    hazard = rs1_busy || idx_hit(ex_valid && ex_rd_we, ex_rd_idx, id_rs1_idx)
          || rs2_busy || idx_hit(ex_valid && ex_rd_we, ex_rd_idx, id_rs2_idx)
          || (id_rd_we && (rd_busy || idx_hit(ex_valid && ex_rd_we, ex_rd_idx, id_rd_idx)));
    id_ready = !flush && !hazard && (!ex_valid || ex_ready);
    id_fire  = id_valid && id_ready;
  end

  // Output register toward execute: load on handshake, drain on consume/flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid  <= 1'b0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_rd_idx <= '0;
      ex_rd_we  <= 1'b0;
      ex_tag    <= '0;
    end else if (id_fire) begin
      ex_valid  <= 1'b1;
      ex_op1    <= op1;
      ex_op2    <= op2;
      ex_rd_idx <= id_rd_idx;
      ex_rd_we  <= id_rd_we;
      ex_tag    <= id_tag;
    end else if (flush || ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

`ifdef OPFETCH_STALL_CNT_EN
  // Count cycles an instruction waits for reasons other than flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            stall_cnt <= '0;
    else if (id_valid && !id_ready && !flush) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a table of single-cycle vectors
// followed by hand-written reset and RAW-stall sequences.
// Honours OPFETCH_STALL_CNT_EN when the design is built with it.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [4:0]  id_rs1_idx = '0, id_rs2_idx = '0, id_rd_idx = '0;
  logic        id_rd_we = 1'b0;
  logic [31:0] id_tag = '0;
  logic [4:0]  rf_rs1_idx, rf_rs2_idx;
  logic [63:0] rf_rd_data_1 = '0, rf_rd_data_2 = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_idx = '0;
  logic [63:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [63:0] ex_op1, ex_op2;
  logic [4:0]  ex_rd_idx;
  logic        ex_rd_we;
  logic [31:0] ex_tag;
`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  operand_fetch #(.DWIDTH(64), .TWIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs1_idx   (id_rs1_idx),
    .id_rs2_idx   (id_rs2_idx),
    .id_rd_idx    (id_rd_idx),
    .id_rd_we     (id_rd_we),
    .id_tag       (id_tag),
    .rf_rs1_idx   (rf_rs1_idx),
    .rf_rs2_idx   (rf_rs2_idx),
    .rf_rd_data_1 (rf_rd_data_1),
    .rf_rd_data_2 (rf_rd_data_2),
    .wb_en        (wb_en),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_rd_idx    (ex_rd_idx),
    .ex_rd_we     (ex_rd_we),
    .ex_tag       (ex_tag)
`ifdef OPFETCH_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] tag;
    logic [63:0] rf1, rf2;
    logic        wbe;
    logic [4:0]  wbi;
    logic [63:0] wbd;
    logic        fl, exr;
    logic        e_rdy, e_ev;
    logic [63:0] e_op1, e_op2;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [31:0] e_tag;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic we, input logic [31:0] tag, input logic [63:0] rf1, input logic [63:0] rf2,
    input logic wbe, input logic [4:0] wbi, input logic [63:0] wbd, input logic fl,
    input logic exr, input logic e_rdy, input logic e_ev, input logic [63:0] e_op1,
    input logic [63:0] e_op2, input logic [4:0] e_rd, input logic e_we, input logic [31:0] e_tag);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.we = we; r.tag = tag;
    r.rf1 = rf1; r.rf2 = rf2; r.wbe = wbe; r.wbi = wbi; r.wbd = wbd;
    r.fl = fl; r.exr = exr; r.e_rdy = e_rdy; r.e_ev = e_ev;
    r.e_op1 = e_op1; r.e_op2 = e_op2; r.e_rd = e_rd; r.e_we = e_we; r.e_tag = e_tag;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1_idx = t.rs1; id_rs2_idx = t.rs2; id_rd_idx = t.rd;
    id_rd_we = t.we; id_tag = t.tag; rf_rd_data_1 = t.rf1; rf_rd_data_2 = t.rf2;
    wb_en = t.wbe; wb_idx = t.wbi; wb_data = t.wbd; flush = t.fl; ex_ready = t.exr;
  endtask

  task automatic check_ex(input string p, input logic ev, input logic [63:0] o1,
                          input logic [63:0] o2, input logic [4:0] rd, input logic we,
                          input logic [31:0] tag);
    chk({p, " ex_valid"},  64'(ex_valid), 64'(ev));
    chk({p, " ex_op1"},    ex_op1, o1);
    chk({p, " ex_op2"},    ex_op2, o2);
    chk({p, " ex_rd_idx"}, 64'(ex_rd_idx), 64'(rd));
    chk({p, " ex_rd_we"},  64'(ex_rd_we), 64'(we));
    chk({p, " ex_tag"},    64'(ex_tag), 64'(tag));
  endtask

  // One cycle with given inputs: comb check before the edge, registered after.
  task automatic step(input string p, input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    chk({p, " id_ready"},   64'(id_ready), 64'(t.e_rdy));
    chk({p, " rf_rs1_idx"}, 64'(rf_rs1_idx), 64'(t.rs1));
    chk({p, " rf_rs2_idx"}, 64'(rf_rs2_idx), 64'(t.rs2));
    @(posedge clk);
    #1;
    check_ex(p, t.e_ev, t.e_op1, t.e_op2, t.e_rd, t.e_we, t.e_tag);
  endtask

  initial begin
    vec_t t;
    // independent stream, back to back
    vecs[0]  = mk(1,1,2,5,1,'h100,'h11,'h22,0,0,0,0,1, 1,1,'h11,'h22,5,1,'h100);
    vecs[1]  = mk(1,1,2,6,1,'h101,'h11,'h22,0,0,0,0,1, 1,1,'h11,'h22,6,1,'h101);
    vecs[2]  = mk(1,1,2,7,1,'h102,'h11,'h22,0,0,0,0,1, 1,1,'h11,'h22,7,1,'h102);
    // same-cycle bypass on rs1, rs2=x0 ignores rf data
    vecs[3]  = mk(1,3,0,0,0,'h103,'h5,'h99,1,3,'hAB,0,1, 1,1,'hAB,0,0,0,'h103);
    // RAW on pending x5: stall twice, accept with bypass in wb cycle
    vecs[4]  = mk(1,1,5,8,1,'h104,'h11,'h22,0,0,0,0,1, 0,0,'hAB,0,0,0,'h103);
    vecs[5]  = mk(1,1,5,8,1,'h104,'h11,'h22,0,0,0,0,1, 0,0,'hAB,0,0,0,'h103);
    vecs[6]  = mk(1,1,5,8,1,'h104,'h11,'h22,1,5,'h555,0,1, 1,1,'h11,'h555,8,1,'h104);
    // WAW on pending x6, released by its writeback
    vecs[7]  = mk(1,1,2,6,1,'h105,'h11,'h22,0,0,0,0,1, 0,0,'h11,'h555,8,1,'h104);
    vecs[8]  = mk(1,1,2,6,1,'h105,'h11,'h22,1,6,'h66,0,1, 1,1,'h11,'h22,6,1,'h105);
    // x0 sources read zero; rd=x0 with we never pends
    vecs[9]  = mk(1,0,0,0,1,'h106,'hFFFF,'hFFFF,0,0,0,0,1, 1,1,0,0,0,1,'h106);
    vecs[10] = mk(1,0,0,1,1,'h107,'hFFFF,'hFFFF,0,0,0,0,1, 1,1,0,0,1,1,'h107);
    // backpressure three cycles, then flush (with ex_ready high)
    vecs[11] = mk(1,2,3,9,0,'h108,'h11,'h22,0,0,0,0,0, 0,1,0,0,1,1,'h107);
    vecs[12] = mk(1,2,3,9,0,'h108,'h11,'h22,0,0,0,0,0, 0,1,0,0,1,1,'h107);
    vecs[13] = mk(1,2,3,9,0,'h108,'h11,'h22,0,0,0,0,0, 0,1,0,0,1,1,'h107);
    vecs[14] = mk(1,2,3,9,0,'h108,'h11,'h22,0,0,0,1,1, 0,0,0,0,1,1,'h107);
    // flushed x1 write did not pend; older pending x7 still blocks
    vecs[15] = mk(1,1,2,9,0,'h109,'h11,'h22,0,0,0,0,1, 1,1,'h11,'h22,9,0,'h109);
    vecs[16] = mk(1,7,2,0,0,'h10A,'h11,'h22,0,0,0,0,1, 0,0,'h11,'h22,9,0,'h109);

    #12;
    check_ex("reset", 1'b0, '0, '0, '0, 1'b0, '0);
`ifdef OPFETCH_STALL_CNT_EN
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) step($sformatf("vec%0d", i), vecs[i]);

    // reset mid-operation: load, hold under backpressure, then async reset
    step("rst_load", mk(1,1,2,10,1,'h200,'h11,'h22,0,0,0,0,1, 1,1,'h11,'h22,10,1,'h200));
    step("rst_hold", mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,'h11,'h22,10,1,'h200));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_ex("async_rst", 1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    reset_n = 1'b1;
    // x7 was pending before reset; it must be forgotten
    step("post_rst", mk(1,7,8,6,1,'h201,'h77,'h88,0,0,0,0,1, 1,1,'h77,'h88,6,1,'h201));

    // RAW stall of five cycles on x4, resolved by its writeback
    step("raw_issue", mk(1,0,0,4,1,'h300,'h1,'h2,0,0,0,0,1, 1,1,0,0,4,1,'h300));
    t = mk(1,0,4,0,0,'h301,'h1,'h2,0,0,0,0,1, 0,0,0,0,4,1,'h300);
    for (int c = 0; c < 5; c++) step($sformatf("raw_stall%0d", c), t);
    step("raw_wb", mk(1,0,4,0,0,'h301,'h1,'h2,1,4,'h444,0,1, 1,1,0,'h444,0,0,'h301));
`ifdef OPFETCH_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
